// File: rtl/rvh_l1d_ar_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rvh_l1d_ar_arbiter_if
//  Brief    : Bank-side AR requests and the shared L2 AR channel of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface rvh_l1d_ar_arbiter_if #(
  parameter int N_BANK   = 4,
  parameter int AR_WIDTH = 77
);
  localparam int IDX_W = $clog2(N_BANK);

  logic [N_BANK-1:0]          bank_arvalid;
  logic [N_BANK*AR_WIDTH-1:0] bank_ar;
  logic [N_BANK-1:0]          bank_arready;
  logic                       l2_arvalid;
  logic [AR_WIDTH-1:0]        l2_ar;
  logic                       l2_arready;
  logic [IDX_W-1:0]           l2_ar_bank;

  // master: the arbiter itself; slave: banks plus L2 seen from outside
  modport master (
    input  bank_arvalid, bank_ar, l2_arready,
    output bank_arready, l2_arvalid, l2_ar, l2_ar_bank
  );

  modport slave (
    output bank_arvalid, bank_ar, l2_arready,
    input  bank_arready, l2_arvalid, l2_ar, l2_ar_bank
  );
endinterface
`default_nettype wire

// File: rtl/rvh_l1d_ar_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rvh_l1d_ar_arbiter
//  Brief    : Round-robin arbiter sharing one L2 AR channel among L1D banks,
//             with a 1-entry registered output buffer.
//             Optional: RVH_L1D_AR_ARB_PERF_EN adds grant/stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module rvh_l1d_ar_arbiter #(
  parameter int N_BANK   = 4,
  parameter int AR_WIDTH = 77
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
`ifdef RVH_L1D_AR_ARB_PERF_EN
  rvh_l1d_ar_arbiter_if.master        ar_if,
  output logic [N_BANK*32-1:0]        perf_grant_cnt_o,
  output logic [31:0]                 perf_stall_cnt_o
`else
  rvh_l1d_ar_arbiter_if.master        ar_if
`endif
);
  localparam int IDX_W = $clog2(N_BANK);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q;
  logic [AR_WIDTH-1:0] ar_q;
  logic [IDX_W-1:0]    bank_q;
  logic [IDX_W-1:0]    rr_ptr_q;

  logic                w_can_load;
  logic                w_gnt_vld;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [N_BANK-1:0]   w_gnt_oh;
  logic [AR_WIDTH-1:0] w_gnt_ar;

  assign w_can_load = (state_q == ST_EMPTY) | ar_if.l2_arready;

  // Scan from rr_ptr+1 upward, wrapping; the first valid bank wins.
  always_comb begin
    int               scan;
    logic [IDX_W-1:0] idx;
    scan      = 0;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    if (rst && w_can_load) begin
      for (int k = 1; k <= N_BANK; k++) begin
        scan = (int'(rr_ptr_q) + k) % N_BANK;
        idx  = IDX_W'(scan);
        if (!w_gnt_vld && ar_if.bank_arvalid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = idx;
        end
      end
    end
    if (w_gnt_vld) begin
      w_gnt_oh[w_gnt_idx] = 1'b1;
    end
  end

  assign w_gnt_ar = ar_if.bank_ar[w_gnt_idx*AR_WIDTH +: AR_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      ar_q     <= '0;
      bank_q   <= '0;
      rr_ptr_q <= IDX_W'(N_BANK - 1);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_gnt_vld) begin
            state_q  <= ST_FULL;
            ar_q     <= w_gnt_ar;
            bank_q   <= w_gnt_idx;
            rr_ptr_q <= w_gnt_idx;
          end
        end
        ST_FULL: begin
          // A drain and a new grant in the same edge reload without a bubble
          if (w_gnt_vld) begin
            ar_q     <= w_gnt_ar;
            bank_q   <= w_gnt_idx;
            rr_ptr_q <= w_gnt_idx;
          end else if (ar_if.l2_arready) begin
            state_q  <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign ar_if.bank_arready = w_gnt_oh;
  assign ar_if.l2_arvalid   = (state_q == ST_FULL);
  assign ar_if.l2_ar        = ar_q;
  assign ar_if.l2_ar_bank   = bank_q;

`ifdef RVH_L1D_AR_ARB_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_FULL) && !ar_if.l2_arready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;

  for (genvar b = 0; b < N_BANK; b++) begin : g_perf_grant
    logic [31:0] grant_cnt_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        grant_cnt_q <= '0;
      end else if (w_gnt_oh[b] && (grant_cnt_q != 32'hFFFF_FFFF)) begin
        grant_cnt_q <= grant_cnt_q + 32'd1;
      end
    end

    assign perf_grant_cnt_o[b*32 +: 32] = grant_cnt_q;
  end
`else
  // Counters are absent in this build; arbitration is unaffected.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_ar_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvh_l1d_ar_arbiter
//  Brief    : Vector table plus hand sequences; payloads tracked in a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvh_l1d_ar_arbiter;
  localparam int N_BANK   = 4;
  localparam int AR_WIDTH = 77;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvh_l1d_ar_arbiter_if #(.N_BANK(N_BANK), .AR_WIDTH(AR_WIDTH)) ar_if ();

`ifdef RVH_L1D_AR_ARB_PERF_EN
  logic [N_BANK*32-1:0] perf_grant_cnt;
  logic [31:0]          perf_stall_cnt;
`endif

  rvh_l1d_ar_arbiter #(.N_BANK(N_BANK), .AR_WIDTH(AR_WIDTH)) u_dut (
    .clk              (clk),
    .rst              (rst),
`ifdef RVH_L1D_AR_ARB_PERF_EN
    .ar_if            (ar_if),
    .perf_grant_cnt_o (perf_grant_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`else
    .ar_if            (ar_if)
`endif
  );

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] exp_gnt;
    logic       exp_l2v;
    logic [1:0] exp_bank;
  } vec_t;

  int                  n_pass  = 0;
  int                  n_total = 0;
  logic [AR_WIDTH-1:0] sbq[$];
  logic [AR_WIDTH-1:0] cur_pay[N_BANK];
  int                  exp_gcnt[N_BANK];
  int                  exp_stall;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic [3:0] vld, input logic rdy, input logic [3:0] eg,
                      input logic el2v, input logic [1:0] eb, input string nm);
    logic [95:0] tmp;
    ar_if.bank_arvalid = vld;
    ar_if.l2_arready   = rdy;
    for (int b = 0; b < N_BANK; b++) begin
      tmp = {$urandom(), $urandom(), $urandom()};
      cur_pay[b] = tmp[AR_WIDTH-1:0];
      ar_if.bank_ar[b*AR_WIDTH +: AR_WIDTH] = cur_pay[b];
    end
    #3;
    check({nm, " gnt"}, 128'(ar_if.bank_arready), 128'(eg));
    check({nm, " l2v"}, 128'(ar_if.l2_arvalid), 128'(el2v));
    if (el2v) begin
      check({nm, " bank"}, 128'(ar_if.l2_ar_bank), 128'(eb));
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL %s ar: output valid but scoreboard empty", nm);
      end else begin
        check({nm, " ar"}, 128'(ar_if.l2_ar), 128'(sbq[0]));
      end
      if (rdy && sbq.size() > 0) void'(sbq.pop_front());
      if (!rdy) exp_stall++;
    end
    for (int b = 0; b < N_BANK; b++) begin
      if (eg[b]) begin
        sbq.push_back(cur_pay[b]);
        exp_gcnt[b]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sbq.delete();
    exp_stall = 0;
    for (int b = 0; b < N_BANK; b++) exp_gcnt[b] = 0;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[7]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0};
    vecs[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3};
    vecs[9]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[12] = '{4'b0110, 1'b0, 4'b0010, 1'b0, 2'd0};
    vecs[13] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[14] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

    rst                = 1'b0;
    ar_if.bank_arvalid = '1;
    ar_if.bank_ar      = '0;
    ar_if.l2_arready   = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("rst%0d gnt", i), 128'(ar_if.bank_arready), 128'd0);
      check($sformatf("rst%0d l2v", i), 128'(ar_if.l2_arvalid), 128'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].vld, vecs[i].rdy, vecs[i].exp_gnt, vecs[i].exp_l2v,
           vecs[i].exp_bank, $sformatf("vec%0d", i));
    end

    // Single requester under backpressure: buffer and payload must hold.
    step(4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, "t3 load");
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, $sformatf("t3 hold%0d", i));
    step(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, "t3 reload");
    step(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, "t3 last");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "t3 idle");

    // Reset while a stalled request is buffered; rr pointer must return to 3.
    step(4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, "t5 load");
    step(4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, "t5 stall");
    rst                = 1'b0;
    ar_if.bank_arvalid = 4'b1111;
    ar_if.l2_arready   = 1'b0;
    #3;
    check("t5 rst gnt", 128'(ar_if.bank_arready), 128'd0);
    @(posedge clk);
    #1;
    clear_model();
    check("t5 rst l2v", 128'(ar_if.l2_arvalid), 128'd0);
    rst = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, "t5 first");
    step(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, "t5 out");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "t5 idle");

`ifdef RVH_L1D_AR_ARB_PERF_EN
    for (int b = 0; b < N_BANK; b++)
      check($sformatf("perf grant%0d", b), 128'(perf_grant_cnt[b*32 +: 32]), 128'(exp_gcnt[b]));
    check("perf stall", 128'(perf_stall_cnt), 128'(exp_stall));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
